// File: rtl/repeated_sub_divider.sv
// repeated_sub_divider
//   Multi-cycle divider using repeated subtraction, one subtraction per clock,
//   organised as a three-state controller (IDLE/RUN/DONE) plus datapath.
//   Intended to sit downstream of the add-and-increment multiplier, taking its
//   DW-bit product as dividend.
// Ports:
//   clk, rst_n    - rising-edge clock, asynchronous active-low reset
//   start         - request, sampled only in IDLE
//   dividend      - DW-bit numerator, latched on the accepting edge
//   divisor       - VW-bit denominator, latched on the accepting edge
//   busy          - high while in RUN or DONE
//   done          - one-cycle completion pulse
//   quotient      - DW-bit result, held until next completion
//   remainder     - VW-bit result, held until next completion
//   div_by_zero   - set on completion of a zero-divisor request, held
module repeated_sub_divider #(
  parameter int unsigned DW = 16,
  parameter int unsigned VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [VW-1:0] div_q, div_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rmd_q, rmd_d;
  logic          dbz_q, dbz_d;
  logic          done_q, done_d;

  logic [DW-1:0] div_ext;

  assign div_ext = {{(DW-VW){1'b0}}, div_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = dividend;
          div_d   = divisor;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // A zero divisor takes one pass through RUN so that its completion
        // lines up with the N=0 case: done one edge after accept, busy low
        // one edge later.
        if (div_q == '0) begin
          quo_d   = '1;
          rmd_d   = '0;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (rem_q >= div_ext) begin
          rem_d = rem_q - div_ext;
          cnt_d = cnt_q + {{(DW-1){1'b0}}, 1'b1};
        end else begin
          // Final remainder is below div_q, so the upper bits are zero.
          quo_d   = cnt_q;
          rmd_d   = rem_q[VW-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_repeated_sub_divider.sv
`timescale 1ns/1ps
module tb_repeated_sub_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int unsigned n_checks;
  int unsigned n_errors;

  repeated_sub_divider #(.DW(16), .VW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division; latency from accept edge to done edge.
  task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r,
                         output logic z, output int unsigned lat);
    if (b == 0) begin
      q = 16'hFFFF; r = 8'd0; z = 1'b1; lat = 1;
    end else begin
      q = a / b; r = 8'(a % b); z = 1'b0; lat = int'(a / b) + 1;
    end
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (busy && n < 10) begin
      @(posedge clk); #1; n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // One transaction with a single-cycle start pulse and junk operands afterwards.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [7:0] b);
    logic [15:0] eq; logic [7:0] er; logic ez; int unsigned lat;
    int unsigned c;
    logic busy_ok;
    ref_div(a, b, eq, er, ez, lat);
    wait_idle();
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 16'($urandom); divisor = 8'($urandom);
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    c = 0; busy_ok = 1'b1;
    while (!done && c < lat + 5) begin
      @(posedge clk); #1; c++;
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, c, lat);
    check({tag, "_busy_hold"}, 32'(busy_ok), 32'd1);
    check({tag, "_quot"}, 32'(quotient), 32'(eq));
    check({tag, "_rem"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    @(posedge clk); #1;
    check({tag, "_after"}, {done, busy, quotient, remainder}, {1'b0, 1'b0, eq, er});
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    int unsigned c;
    int unsigned pulses;
    n_checks = 0; n_errors = 0;
    start = 1'b0; dividend = '0; divisor = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, quotient, remainder, div_by_zero}, '0);
    @(negedge clk); rst_n = 1'b1;

    do_op("d100_7", 16'd100, 8'd7);
    do_op("d5_9", 16'd5, 8'd9);
    do_op("d1234_0", 16'd1234, 8'd0);
    do_op("d10_3", 16'd10, 8'd3);

    // start held high, operands changed during RUN
    wait_idle();
    @(negedge clk);
    start = 1'b1; dividend = 16'd200; divisor = 8'd10;
    @(posedge clk); #1;
    c = 0;
    while (!done && c < 30) begin
      @(posedge clk); #1; c++;
      if (c == 5) begin dividend = 16'd50; divisor = 8'd5; end
    end
    check("held_latency", c, 32'd21);
    check("held_first", {quotient, remainder, div_by_zero}, {16'd20, 8'd0, 1'b0});
    @(posedge clk); #1;
    check("held_gap", {done, busy}, 2'b00);
    c = 0;
    while (!busy && c < 3) begin @(posedge clk); #1; c++; end
    start = 1'b0;
    check("held_reaccept", 32'(busy), 32'd1);
    c = 0; pulses = 0;
    while (c < 20) begin
      if (done) pulses++;
      @(posedge clk); #1; c++;
    end
    check("held_pulses", pulses, 32'd1);
    check("held_second", {quotient, remainder, div_by_zero}, {16'd10, 8'd0, 1'b0});

    // reset mid-operation
    wait_idle();
    @(negedge clk);
    start = 1'b1; dividend = 16'd200; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {busy, done, quotient, remainder, div_by_zero}, '0);
    pulses = 0;
    repeat (2) begin @(posedge clk); #1; if (done) pulses++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (done || busy) pulses++; end
    check("midrst_quiet", pulses, 32'd0);
    do_op("d200_3", 16'd200, 8'd3);

    do_op("d65025_255", 16'd65025, 8'd255);
    do_op("d65535_1", 16'd65535, 8'd1);

    // randomized operations, divisor kept large enough to bound latency
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = 8'd0;
      else b = 8'($urandom_range(255, int'(a >> 9) + 1));
      do_op("rand", a, b);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
